pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg_if.sv | 27 ++
 rtl/pipe_stage_reg.sv | 93 +++++++++
 tb/tb_pipe_stage_reg.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle around one pipeline stage: upstream valid/ready/payload in,
// downstream valid/ready/payload out. The stage itself connects through the slave view.
interface pipe_stage_reg_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CTRL_W = 8
);
    logic              in_valid_i;
    logic              in_ready_o;
    logic [DATA_W-1:0] in_data_i;
    logic [CTRL_W-1:0] in_ctrl_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [DATA_W-1:0] out_data_o;
    logic [CTRL_W-1:0] out_ctrl_o;

    // Producer/consumer environment side
    modport master (
        output in_valid_i, in_data_i, in_ctrl_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_data_o, out_ctrl_o
    );

    // Pipeline stage side
    modport slave (
        input  in_valid_i, in_data_i, in_ctrl_i, out_ready_i,
        output in_ready_o, out_valid_o, out_data_o, out_ctrl_o
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline register with optional two-entry skid buffer; control field
// is masked to zero whenever the stage presents a bubble.
module pipe_stage_reg #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned CTRL_W  = 8,
    parameter int unsigned SKID_EN = 1
) (
    input  logic                 clk,
    input  logic                 rst_i,
    input  logic                 flush_i,
    pipe_stage_reg_if.slave      bus,
    output logic [1:0]           occupancy_o
);
    // Encoding doubles as the occupancy count
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_main_data;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic [DATA_W-1:0] r_skid_data;
    logic [CTRL_W-1:0] r_skid_ctrl;

    logic w_in_ready;
    logic w_out_valid;
    logic w_accept;
    logic w_pop;

    // Skid mode keeps ready free of any path from out_ready_i
    generate
        if (SKID_EN != 0) begin : g_skid_ready
            assign w_in_ready = !rst_i && (r_state != ST_TWO);
        end else begin : g_pass_ready
            assign w_in_ready = !rst_i && ((r_state == ST_EMPTY) || bus.out_ready_i);
        end
    endgenerate

    assign w_out_valid = (r_state != ST_EMPTY);
    assign w_accept    = bus.in_valid_i && w_in_ready;
    assign w_pop       = w_out_valid && bus.out_ready_i;

    always_ff @(posedge clk) begin
        if (rst_i) begin
            r_state     <= ST_EMPTY;
            r_main_data <= '0;
            r_main_ctrl <= '0;
            r_skid_data <= '0;
            r_skid_ctrl <= '0;
        end else if (flush_i) begin
            r_state <= ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        r_main_data <= bus.in_data_i;
                        r_main_ctrl <= bus.in_ctrl_i;
                        r_state     <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_pop) begin
                        r_main_data <= bus.in_data_i;
                        r_main_ctrl <= bus.in_ctrl_i;
                    end else if (w_pop) begin
                        r_state <= ST_EMPTY;
                    end else if (w_accept && (SKID_EN != 0)) begin
                        r_skid_data <= bus.in_data_i;
                        r_skid_ctrl <= bus.in_ctrl_i;
                        r_state     <= ST_TWO;
                    end
                end
                ST_TWO: begin
                    if (w_pop) begin
                        r_main_data <= r_skid_data;
                        r_main_ctrl <= r_skid_ctrl;
                        r_state     <= ST_ONE;
                    end
                end
                default: r_state <= ST_EMPTY;
            endcase
        end
    end

    // Data holds its last value across bubbles; control never leaks out of one
    assign bus.in_ready_o  = w_in_ready;
    assign bus.out_valid_o = w_out_valid;
    assign bus.out_data_o  = r_main_data;
    assign bus.out_ctrl_o  = w_out_valid ? r_main_ctrl : CTRL_W'(0);
    assign occupancy_o     = 2'(r_state);
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: one skid-buffered instance and one pass-through
// instance, each scenario a task with its own hand-computed expectations.
module tb_pipe_stage_reg;
    logic       clk = 1'b0;
    logic       rst_i;
    logic       flush_i;
    logic [1:0] occ_s;
    logic [1:0] occ_p;
    int         errors = 0;
    int         checks = 0;

    pipe_stage_reg_if #(.DATA_W(32), .CTRL_W(8)) bus_s ();
    pipe_stage_reg_if #(.DATA_W(32), .CTRL_W(8)) bus_p ();

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .SKID_EN(1)) u_skid (
        .clk         (clk),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .bus         (bus_s),
        .occupancy_o (occ_s)
    );

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .SKID_EN(0)) u_pass (
        .clk         (clk),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .bus         (bus_p),
        .occupancy_o (occ_p)
    );

    always #5 clk = ~clk;

    // Advance one edge and settle away from it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        tick();
        tick();
        checks++; if (bus_s.out_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", bus_s.out_valid_o); end
        checks++; if (occ_s !== 2'd0) begin errors++; $display("FAIL rst_occ: got %0d want 0", occ_s); end
        checks++; if (bus_s.in_ready_o !== 1'b0) begin errors++; $display("FAIL rst_ready_skid: got %b want 0", bus_s.in_ready_o); end
        checks++; if (bus_p.in_ready_o !== 1'b0) begin errors++; $display("FAIL rst_ready_pass: got %b want 0", bus_p.in_ready_o); end
        checks++; if (bus_s.out_data_o !== 32'h0) begin errors++; $display("FAIL rst_data: got %h want 0", bus_s.out_data_o); end
        checks++; if (bus_s.out_ctrl_o !== 8'h0) begin errors++; $display("FAIL rst_ctrl: got %h want 0", bus_s.out_ctrl_o); end
        rst_i = 1'b0;
        #1;
        checks++; if (bus_s.in_ready_o !== 1'b1) begin errors++; $display("FAIL rst_release_skid: got %b want 1", bus_s.in_ready_o); end
        checks++; if (bus_p.in_ready_o !== 1'b1) begin errors++; $display("FAIL rst_release_pass: got %b want 1", bus_p.in_ready_o); end
    endtask

    task automatic test_streaming();
        bus_s.out_ready_i = 1'b1;
        bus_s.in_valid_i  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus_s.in_data_i = 32'h10 + 32'(i);
            bus_s.in_ctrl_i = 8'(i + 1);
            tick();
            checks++; if (bus_s.out_valid_o !== 1'b1) begin errors++; $display("FAIL stream_valid%0d: got %b want 1", i, bus_s.out_valid_o); end
            checks++; if (bus_s.out_data_o !== 32'h10 + 32'(i)) begin errors++; $display("FAIL stream_data%0d: got %h want %h", i, bus_s.out_data_o, 32'h10 + 32'(i)); end
            checks++; if (bus_s.out_ctrl_o !== 8'(i + 1)) begin errors++; $display("FAIL stream_ctrl%0d: got %h want %h", i, bus_s.out_ctrl_o, 8'(i + 1)); end
            checks++; if (occ_s !== 2'd1) begin errors++; $display("FAIL stream_occ%0d: got %0d want 1", i, occ_s); end
        end
        bus_s.in_valid_i = 1'b0;
        tick();
        checks++; if (bus_s.out_valid_o !== 1'b0) begin errors++; $display("FAIL stream_drain_valid: got %b want 0", bus_s.out_valid_o); end
        checks++; if (bus_s.out_data_o !== 32'h12) begin errors++; $display("FAIL stream_drain_hold: got %h want 12", bus_s.out_data_o); end
    endtask

    task automatic test_backpressure();
        bus_s.out_ready_i = 1'b0;
        bus_s.in_valid_i  = 1'b1;
        bus_s.in_data_i   = 32'hA;
        bus_s.in_ctrl_i   = 8'h0A;
        tick();
        bus_s.in_data_i   = 32'hB;
        bus_s.in_ctrl_i   = 8'h0B;
        tick();
        checks++; if (occ_s !== 2'd2) begin errors++; $display("FAIL bp_occ2: got %0d want 2", occ_s); end
        checks++; if (bus_s.in_ready_o !== 1'b0) begin errors++; $display("FAIL bp_ready0: got %b want 0", bus_s.in_ready_o); end
        checks++; if (bus_s.out_data_o !== 32'hA) begin errors++; $display("FAIL bp_head: got %h want a", bus_s.out_data_o); end
        // Offer while full: must be ignored
        bus_s.in_data_i = 32'hC;
        bus_s.in_ctrl_i = 8'h0C;
        tick();
        checks++; if (occ_s !== 2'd2) begin errors++; $display("FAIL bp_full_hold_occ: got %0d want 2", occ_s); end
        checks++; if (bus_s.out_data_o !== 32'hA) begin errors++; $display("FAIL bp_full_hold_data: got %h want a", bus_s.out_data_o); end
        bus_s.in_valid_i  = 1'b0;
        bus_s.out_ready_i = 1'b1;
        tick();
        checks++; if (bus_s.out_data_o !== 32'hB) begin errors++; $display("FAIL bp_second: got %h want b", bus_s.out_data_o); end
        checks++; if (bus_s.out_ctrl_o !== 8'h0B) begin errors++; $display("FAIL bp_second_ctrl: got %h want 0b", bus_s.out_ctrl_o); end
        checks++; if (occ_s !== 2'd1) begin errors++; $display("FAIL bp_occ1: got %0d want 1", occ_s); end
        checks++; if (bus_s.in_ready_o !== 1'b1) begin errors++; $display("FAIL bp_ready1: got %b want 1", bus_s.in_ready_o); end
        tick();
        checks++; if (bus_s.out_valid_o !== 1'b0) begin errors++; $display("FAIL bp_empty: got %b want 0", bus_s.out_valid_o); end
    endtask

    task automatic test_flush();
        bus_s.out_ready_i = 1'b0;
        bus_s.in_valid_i  = 1'b1;
        bus_s.in_data_i   = 32'h1;
        bus_s.in_ctrl_i   = 8'h11;
        tick();
        bus_s.in_data_i   = 32'h2;
        bus_s.in_ctrl_i   = 8'h22;
        tick();
        checks++; if (occ_s !== 2'd2) begin errors++; $display("FAIL flush_pre_occ: got %0d want 2", occ_s); end
        flush_i         = 1'b1;
        bus_s.in_data_i = 32'h3;
        bus_s.in_ctrl_i = 8'h33;
        tick();
        flush_i          = 1'b0;
        bus_s.in_valid_i = 1'b0;
        checks++; if (occ_s !== 2'd0) begin errors++; $display("FAIL flush_occ: got %0d want 0", occ_s); end
        checks++; if (bus_s.out_valid_o !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", bus_s.out_valid_o); end
        checks++; if (bus_s.out_ctrl_o !== 8'h0) begin errors++; $display("FAIL flush_ctrl: got %h want 0", bus_s.out_ctrl_o); end
        bus_s.out_ready_i = 1'b1;
        tick();
        tick();
        checks++; if (bus_s.out_valid_o !== 1'b0) begin errors++; $display("FAIL flush_no_ghost: got %b want 0", bus_s.out_valid_o); end
        bus_s.in_valid_i = 1'b1;
        bus_s.in_data_i  = 32'h4;
        bus_s.in_ctrl_i  = 8'h44;
        tick();
        bus_s.in_valid_i = 1'b0;
        checks++; if (bus_s.out_data_o !== 32'h4) begin errors++; $display("FAIL flush_recover: got %h want 4", bus_s.out_data_o); end
        tick();
    endtask

    task automatic test_bubble();
        bus_s.out_ready_i = 1'b0;
        bus_s.in_valid_i  = 1'b1;
        bus_s.in_data_i   = 32'h55;
        bus_s.in_ctrl_i   = 8'hFF;
        tick();
        checks++; if (bus_s.out_ctrl_o !== 8'hFF) begin errors++; $display("FAIL bubble_ctrl_live: got %h want ff", bus_s.out_ctrl_o); end
        bus_s.in_valid_i  = 1'b0;
        bus_s.out_ready_i = 1'b1;
        tick();
        checks++; if (bus_s.out_valid_o !== 1'b0) begin errors++; $display("FAIL bubble_valid: got %b want 0", bus_s.out_valid_o); end
        checks++; if (bus_s.out_ctrl_o !== 8'h00) begin errors++; $display("FAIL bubble_ctrl: got %h want 00", bus_s.out_ctrl_o); end
        checks++; if (bus_s.out_data_o !== 32'h55) begin errors++; $display("FAIL bubble_data: got %h want 55", bus_s.out_data_o); end
        tick();
        checks++; if (bus_s.out_data_o !== 32'h55) begin errors++; $display("FAIL bubble_data_hold: got %h want 55", bus_s.out_data_o); end
    endtask

    task automatic test_pass_through();
        bus_p.out_ready_i = 1'b0;
        bus_p.in_valid_i  = 1'b1;
        bus_p.in_data_i   = 32'h20;
        bus_p.in_ctrl_i   = 8'h02;
        tick();
        bus_p.in_data_i   = 32'h21;
        bus_p.in_ctrl_i   = 8'h03;
        #1;
        checks++; if (bus_p.in_ready_o !== 1'b0) begin errors++; $display("FAIL pass_ready0: got %b want 0", bus_p.in_ready_o); end
        tick();
        checks++; if (bus_p.out_data_o !== 32'h20) begin errors++; $display("FAIL pass_hold: got %h want 20", bus_p.out_data_o); end
        checks++; if (occ_p !== 2'd1) begin errors++; $display("FAIL pass_hold_occ: got %0d want 1", occ_p); end
        bus_p.out_ready_i = 1'b1;
        #1;
        checks++; if (bus_p.in_ready_o !== 1'b1) begin errors++; $display("FAIL pass_ready1: got %b want 1", bus_p.in_ready_o); end
        tick();
        checks++; if (bus_p.out_data_o !== 32'h21) begin errors++; $display("FAIL pass_next: got %h want 21", bus_p.out_data_o); end
        checks++; if (occ_p !== 2'd1) begin errors++; $display("FAIL pass_occ: got %0d want 1", occ_p); end
        bus_p.in_data_i = 32'h22;
        bus_p.in_ctrl_i = 8'h04;
        tick();
        checks++; if (bus_p.out_data_o !== 32'h22) begin errors++; $display("FAIL pass_stream: got %h want 22", bus_p.out_data_o); end
        checks++; if (bus_p.out_ctrl_o !== 8'h04) begin errors++; $display("FAIL pass_stream_ctrl: got %h want 04", bus_p.out_ctrl_o); end
        bus_p.in_valid_i = 1'b0;
        tick();
        checks++; if (bus_p.out_valid_o !== 1'b0) begin errors++; $display("FAIL pass_drain: got %b want 0", bus_p.out_valid_o); end
    endtask

    task automatic test_reset_mid();
        bus_s.out_ready_i = 1'b0;
        bus_s.in_valid_i  = 1'b1;
        bus_s.in_data_i   = 32'h30;
        bus_s.in_ctrl_i   = 8'h30;
        tick();
        bus_s.in_data_i   = 32'h31;
        bus_s.in_ctrl_i   = 8'h31;
        tick();
        checks++; if (occ_s !== 2'd2) begin errors++; $display("FAIL rmid_pre_occ: got %0d want 2", occ_s); end
        rst_i           = 1'b1;
        bus_s.in_data_i = 32'h32;
        bus_s.in_ctrl_i = 8'h32;
        tick();
        checks++; if (bus_s.out_valid_o !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b want 0", bus_s.out_valid_o); end
        checks++; if (bus_s.out_data_o !== 32'h0) begin errors++; $display("FAIL rmid_data: got %h want 0", bus_s.out_data_o); end
        checks++; if (bus_s.in_ready_o !== 1'b0) begin errors++; $display("FAIL rmid_ready: got %b want 0", bus_s.in_ready_o); end
        rst_i            = 1'b0;
        bus_s.in_valid_i = 1'b0;
        #1;
        checks++; if (bus_s.in_ready_o !== 1'b1) begin errors++; $display("FAIL rmid_release: got %b want 1", bus_s.in_ready_o); end
        bus_s.in_valid_i = 1'b1;
        bus_s.in_data_i  = 32'h40;
        bus_s.in_ctrl_i  = 8'h44;
        tick();
        bus_s.in_valid_i = 1'b0;
        checks++; if (bus_s.out_data_o !== 32'h40) begin errors++; $display("FAIL rmid_first_data: got %h want 40", bus_s.out_data_o); end
        checks++; if (bus_s.out_ctrl_o !== 8'h44) begin errors++; $display("FAIL rmid_first_ctrl: got %h want 44", bus_s.out_ctrl_o); end
        checks++; if (occ_s !== 2'd1) begin errors++; $display("FAIL rmid_first_occ: got %0d want 1", occ_s); end
    endtask

    initial begin
        rst_i             = 1'b1;
        flush_i           = 1'b0;
        bus_s.in_valid_i  = 1'b0;
        bus_s.in_data_i   = '0;
        bus_s.in_ctrl_i   = '0;
        bus_s.out_ready_i = 1'b0;
        bus_p.in_valid_i  = 1'b0;
        bus_p.in_data_i   = '0;
        bus_p.in_ctrl_i   = '0;
        bus_p.out_ready_i = 1'b0;

        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_bubble();
        test_pass_through();
        test_reset_mid();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
